// File: rtl/npuarc_mmu_ntlb_ram_pkg.sv
// ---------------------------------------------------------------------------
// npuarc_mmu_ntlb_ram_pkg
// Shared definitions for the nTLB RAM controller:
//   - pm_state encoding (PM_ACTIVE..PM_WAKE) and its width PM_W
//   - width of the idle / wake counters in the power FSM
//   - even_parity(): parity bit such that word+bit has an even number of ones
// Optional parity storage in the top is enabled by NPUARC_MMU_NTLB_RAM_PARITY_EN.
// ---------------------------------------------------------------------------
package npuarc_mmu_ntlb_ram_pkg;

    localparam int PM_W  = 3;
    localparam int CNT_W = 16;

    localparam logic [PM_W-1:0] PM_ACTIVE = 3'd0;
    localparam logic [PM_W-1:0] PM_LS     = 3'd1;
    localparam logic [PM_W-1:0] PM_DS     = 3'd2;
    localparam logic [PM_W-1:0] PM_SD     = 3'd3;
    localparam logic [PM_W-1:0] PM_WAKE   = 3'd4;

    // Callers zero-extend their word to 64 bits; zero padding does not
    // change the parity.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/npuarc_mmu_ntlb_ram_pmfsm.sv
// ---------------------------------------------------------------------------
// npuarc_mmu_ntlb_ram_pmfsm
// Power-mode FSM of the nTLB RAM controller with its idle and wake counters.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid       request activity (keeps ACTIVE awake, wakes from LS)
//   pm_ds_req       level request for deep-sleep
//   pm_sd_req       level request for shutdown (wins over deep-sleep)
//   state           current power state (PM_* encoding), also a debug view
//   clr_valid       one-cycle strobe on the cycle that transitions into SD
// ---------------------------------------------------------------------------
module npuarc_mmu_ntlb_ram_pmfsm
    import npuarc_mmu_ntlb_ram_pkg::*;
#(
    parameter int IDLE_LS_CYC = 8,
    parameter int WAKE_DS_CYC = 4,
    parameter int WAKE_SD_CYC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic            pm_ds_req,
    input  logic            pm_sd_req,
    output logic [PM_W-1:0] state,
    output logic            clr_valid
);

    logic [PM_W-1:0]  state_q, state_nxt;
    logic [CNT_W-1:0] idle_cnt, idle_nxt;
    logic [CNT_W-1:0] wake_cnt, wake_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PM_ACTIVE;
            idle_cnt <= '0;
            wake_cnt <= '0;
        end else begin
            state_q  <= state_nxt;
            idle_cnt <= idle_nxt;
            wake_cnt <= wake_nxt;
        end
    end

    // Next-state logic. Idle counter only runs while ACTIVE and idle; every
    // other path leaves it at zero so ACTIVE is always entered with a fresh count.
    always_comb begin
        state_nxt = state_q;
        idle_nxt  = '0;
        wake_nxt  = wake_cnt;
        case (state_q)
            PM_ACTIVE: begin
                if (pm_sd_req)      state_nxt = PM_SD;
                else if (pm_ds_req) state_nxt = PM_DS;
                else if (!req_valid && (IDLE_LS_CYC != 0)) begin
                    if (idle_cnt == CNT_W'(IDLE_LS_CYC - 1)) state_nxt = PM_LS;
                    else                                     idle_nxt  = idle_cnt + 1'b1;
                end
            end
            PM_LS: begin
                if (pm_sd_req)      state_nxt = PM_SD;
                else if (pm_ds_req) state_nxt = PM_DS;
                else if (req_valid) state_nxt = PM_ACTIVE;
            end
            PM_DS: begin
                if (pm_sd_req) state_nxt = PM_SD;
                else if (!pm_ds_req) begin
                    state_nxt = PM_WAKE;
                    wake_nxt  = CNT_W'(WAKE_DS_CYC - 1);
                end
            end
            PM_SD: begin
                if (pm_sd_req)      state_nxt = PM_SD;
                else if (pm_ds_req) state_nxt = PM_DS;
                else begin
                    state_nxt = PM_WAKE;
                    wake_nxt  = CNT_W'(WAKE_SD_CYC - 1);
                end
            end
            PM_WAKE: begin
                if (pm_sd_req)           state_nxt = PM_SD;
                else if (pm_ds_req)      state_nxt = PM_DS;
                else if (wake_cnt == '0) state_nxt = PM_ACTIVE;
                else                     wake_nxt  = wake_cnt - 1'b1;
            end
            default: state_nxt = PM_ACTIVE;
        endcase
    end

    // Outputs: the clear strobe fires on the edge that enters SD so the
    // valid bits are gone from the first SD cycle on.
    always_comb begin
        state     = state_q;
        clr_valid = (state_nxt == PM_SD) && (state_q != PM_SD);
    end

endmodule

// File: rtl/npuarc_mmu_ntlb_ram_ctrl.sv
// ---------------------------------------------------------------------------
// npuarc_mmu_ntlb_ram_ctrl
// Single-port nTLB data/tag array with per-entry valid bits, a registered
// 1-cycle read return and a power-mode FSM (light-sleep, deep-sleep,
// shutdown, timed wake-up). Shutdown drops all entries.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   req_valid / req_ready     request handshake
//   req_we, req_addr, req_wdata  access type, entry index, write data
//   pm_ds_req, pm_sd_req      level power requests (shutdown has priority)
//   rd_valid, rd_data         read return, data held until the next return
//   pm_state                  0=ACTIVE 1=LS 2=DS 3=SD 4=WAKE
//   par_err                   parity error, qualified by rd_valid
// Build option: NPUARC_MMU_NTLB_RAM_PARITY_EN adds one even-parity bit per
// entry and drives par_err; without it par_err is tied low.
//
// Handshake: a request transfers on a cycle where req_valid && req_ready are
// both high; req_ready is combinational from the power state and the pm
// request inputs and does not depend on req_valid.
// ---------------------------------------------------------------------------
module npuarc_mmu_ntlb_ram_ctrl
    import npuarc_mmu_ntlb_ram_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 7,
    parameter int DEPTH       = 128,
    parameter int IDLE_LS_CYC = 8,
    parameter int WAKE_DS_CYC = 4,
    parameter int WAKE_SD_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              pm_ds_req,
    input  logic              pm_sd_req,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [PM_W-1:0]   pm_state,
    output logic              par_err
);

    logic              clr_valid;
    logic              req_acc, wr_acc, rd_acc, in_range;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [DATA_W-1:0] rd_word;

    npuarc_mmu_ntlb_ram_pmfsm #(
        .IDLE_LS_CYC (IDLE_LS_CYC),
        .WAKE_DS_CYC (WAKE_DS_CYC),
        .WAKE_SD_CYC (WAKE_SD_CYC)
    ) u_pmfsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .pm_ds_req (pm_ds_req),
        .pm_sd_req (pm_sd_req),
        .state     (pm_state),
        .clr_valid (clr_valid)
    );

    assign req_ready = (pm_state == PM_ACTIVE) && !pm_ds_req && !pm_sd_req;
    assign req_acc   = req_valid && req_ready;
    // One extra bit so the compare stays meaningful when DEPTH == 2**ADDR_W.
    assign in_range  = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
    assign wr_acc    = req_acc && req_we && in_range;
    assign rd_acc    = req_acc && !req_we;
    assign rd_word   = (in_range && vld[req_addr]) ? mem[req_addr] : '0;

    // Storage array: no reset, contents are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[req_addr] <= req_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         vld <= '0;
        else if (clr_valid) vld <= '0;
        else if (wr_acc)    vld[req_addr] <= 1'b1;
    end

    // Read return pipe; rd_data holds its value between returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= rd_word;
        end
    end

`ifdef NPUARC_MMU_NTLB_RAM_PARITY_EN
    // Error-injection hook: held low in the design, overridden from a bench.
    logic             par_inj;
    logic [DEPTH-1:0] par_mem;
    logic             par_err_q;

    assign par_inj = 1'b0;

    always_ff @(posedge clk) begin
        if (wr_acc) par_mem[req_addr] <= even_parity(64'(req_wdata)) ^ par_inj;
    end

    // Invalid or out-of-range entries never flag an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_err_q <= 1'b0;
        else        par_err_q <= rd_acc && in_range && vld[req_addr] &&
                                 (even_parity(64'(mem[req_addr])) != par_mem[req_addr]);
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule
